// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - registered RISC-V immediate generator with skid buffer
module imm_gen_pipe #(
  parameter int XLEN = 64,
  parameter int PC_W = XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instruction,
  input  logic [PC_W-1:0] pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      imm_fmt,
  output logic [PC_W-1:0] target,
  output logic [PC_W-1:0] out_pc
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] pc;
  } entry_t;

  entry_t dec;
  entry_t or_q;
  entry_t sr_q;
  logic   or_valid;
  logic   sr_valid;

  logic [31:0] imm32;
  logic [63:0] imm_ext;
  logic [2:0]  fmt;
  logic        use_target;
  logic        accept;
  logic        consume;

  // Every format fits in 32 bits, so decode there and sign-extend once.
  always_comb begin
    imm32      = '0;
    fmt        = FMT_NONE;
    use_target = 1'b0;
    case (instruction[6:0])
      7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111: begin
        fmt   = FMT_I;
        imm32 = {{20{instruction[31]}}, instruction[31:20]};
      end
      7'b0100011: begin
        fmt   = FMT_S;
        imm32 = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
      end
      7'b1100011: begin
        fmt        = FMT_B;
        use_target = 1'b1;
        imm32      = {{19{instruction[31]}}, instruction[31], instruction[7],
                      instruction[30:25], instruction[11:8], 1'b0};
      end
      7'b0110111: begin
        fmt   = FMT_U;
        imm32 = {instruction[31:12], 12'b0};
      end
      7'b0010111: begin
        fmt        = FMT_U;
        use_target = 1'b1;
        imm32      = {instruction[31:12], 12'b0};
      end
      7'b1101111: begin
        fmt        = FMT_J;
        use_target = 1'b1;
        imm32      = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                      instruction[20], instruction[30:21], 1'b0};
      end
      default: begin
        fmt   = FMT_NONE;
        imm32 = '0;
      end
    endcase
  end

  always_comb begin
    imm_ext    = {{32{imm32[31]}}, imm32};
    dec.imm    = imm_ext[XLEN-1:0];
    dec.fmt    = fmt;
    dec.pc     = pc;
    dec.target = use_target ? (pc + imm_ext[PC_W-1:0]) : '0;
  end

  assign in_ready = !sr_valid;
  assign accept   = in_valid && in_ready;
  assign consume  = or_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      or_valid <= 1'b0;
      sr_valid <= 1'b0;
      or_q     <= '0;
      sr_q     <= '0;
    end else if (flush) begin
      or_valid <= 1'b0;
      sr_valid <= 1'b0;
    end else if (!or_valid || consume) begin
      // SR is older than anything arriving now, so it drains first.
      if (sr_valid) begin
        or_q     <= sr_q;
        or_valid <= 1'b1;
        sr_valid <= accept;
        if (accept) sr_q <= dec;
      end else begin
        or_valid <= accept;
        if (accept) or_q <= dec;
      end
    end else if (accept) begin
      sr_q     <= dec;
      sr_valid <= 1'b1;
    end
  end

  assign out_valid = or_valid;
  assign imm       = or_q.imm;
  assign imm_fmt   = or_q.fmt;
  assign target    = or_q.target;
  assign out_pc    = or_q.pc;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - directed vectors and handshake sequences for imm_gen_pipe
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instruction;
  logic [63:0] pc;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] imm;
  logic [2:0]  imm_fmt;
  logic [63:0] target;
  logic [63:0] out_pc;

  logic        in_valid32;
  logic        in_ready32;
  logic [31:0] instruction32;
  logic [31:0] pc32;
  logic        out_valid32;
  logic        out_ready32;
  logic [31:0] imm32;
  logic [2:0]  imm_fmt32;
  logic [31:0] target32;
  logic [31:0] out_pc32;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(64), .PC_W(64)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .pc(pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .imm(imm), .imm_fmt(imm_fmt), .target(target), .out_pc(out_pc)
  );

  imm_gen_pipe #(.XLEN(32), .PC_W(32)) dut32 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid32), .in_ready(in_ready32),
    .instruction(instruction32), .pc(pc32),
    .out_valid(out_valid32), .out_ready(out_ready32),
    .imm(imm32), .imm_fmt(imm_fmt32), .target(target32), .out_pc(out_pc32)
  );

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic [63:0] tgt;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_one(input logic [31:0] i, input logic [63:0] p);
    @(negedge clk);
    instruction = i;
    pc          = p;
    in_valid    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_idx;
    int got;
    logic [31:0] bp_inst[4];
    logic [63:0] bp_imm[4];
    logic [63:0] held_pc;

    vecs[0]  = '{32'hFFC12083, 64'h1000, 64'hFFFFFFFFFFFFFFFC, 3'd1, 64'h0};
    vecs[1]  = '{32'hFE112E23, 64'h1004, 64'hFFFFFFFFFFFFFFFC, 3'd2, 64'h0};
    vecs[2]  = '{32'hFE000CE3, 64'h100,  64'hFFFFFFFFFFFFFFF8, 3'd3, 64'hF8};
    vecs[3]  = '{32'h800000B7, 64'h104,  64'hFFFFFFFF80000000, 3'd4, 64'h0};
    vecs[4]  = '{32'h0010006F, 64'h200,  64'h800,              3'd5, 64'hA00};
    vecs[5]  = '{32'h00001097, 64'h300,  64'h1000,             3'd4, 64'h1300};
    vecs[6]  = '{32'hFFFFF097, 64'h0,    64'hFFFFFFFFFFFFF000, 3'd4, 64'hFFFFFFFFFFFFF000};
    vecs[7]  = '{32'h7FF00013, 64'h10,   64'h7FF,              3'd1, 64'h0};
    vecs[8]  = '{32'h8000001B, 64'h14,   64'hFFFFFFFFFFFFF800, 3'd1, 64'h0};
    vecs[9]  = '{32'h00008067, 64'h18,   64'h0,                3'd1, 64'h0};
    vecs[10] = '{32'h7E000FE3, 64'hFFFFFFFFFFFFFFFE, 64'hFFE, 3'd3, 64'hFFC};
    vecs[11] = '{32'h8000006F, 64'h100000, 64'hFFFFFFFFFFF00000, 3'd5, 64'h0};
    vecs[12] = '{32'h0000007F, 64'h40,   64'h0,                3'd0, 64'h0};

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    instruction = '0; pc = '0;
    in_valid32 = 1'b0; out_ready32 = 1'b1; instruction32 = '0; pc32 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_in_ready",  {63'd0, in_ready},  64'd1);
    chk("reset_imm",       imm,                64'd0);
    chk("reset_fmt",       {61'd0, imm_fmt},   64'd0);
    chk("reset_target",    target,             64'd0);
    chk("reset_out_pc",    out_pc,             64'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int v = 0; v < 13; v++) begin
      push_one(vecs[v].inst, vecs[v].pc);
      chk($sformatf("vec%0d_valid", v),  {63'd0, out_valid}, 64'd1);
      chk($sformatf("vec%0d_imm", v),    imm,                vecs[v].imm);
      chk($sformatf("vec%0d_fmt", v),    {61'd0, imm_fmt},   {61'd0, vecs[v].fmt});
      chk($sformatf("vec%0d_target", v), target,             vecs[v].tgt);
      chk($sformatf("vec%0d_pc", v),     out_pc,             vecs[v].pc);
    end
    @(posedge clk);
    #1;
    chk("drain_idle", {63'd0, out_valid}, 64'd0);

    // XLEN=32 instance: U sign extension and wrapping jal target.
    @(negedge clk);
    instruction32 = 32'h800000B7; pc32 = 32'h0; in_valid32 = 1'b1;
    @(posedge clk); #1;
    chk("x32_lui_imm", {32'd0, imm32}, 64'h80000000);
    chk("x32_lui_fmt", {61'd0, imm_fmt32}, 64'd4);
    @(negedge clk);
    instruction32 = 32'h0010006F; pc32 = 32'hFFFFFFF0;
    @(posedge clk); #1;
    chk("x32_jal_target", {32'd0, target32}, 64'h7F0);
    @(negedge clk);
    instruction32 = 32'hFFC12083; pc32 = 32'h1000;
    @(posedge clk); #1;
    chk("x32_lw_imm", {32'd0, imm32}, 64'hFFFFFFFC);
    chk("x32_valid", {63'd0, out_valid32}, 64'd1);
    in_valid32 = 1'b0;

    // Back-pressure: 4 addi's with distinct immediates, out_ready low for 4 cycles.
    for (int k = 0; k < 4; k++) begin
      bp_inst[k] = {12'(k + 1), 20'h00013};
      bp_imm[k]  = 64'(k + 1);
    end
    acc_idx = 0;
    got     = 0;
    held_pc = '0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      @(negedge clk);
      in_valid    = (acc_idx < 4);
      instruction = bp_inst[acc_idx < 4 ? acc_idx : 3];
      pc          = 64'h2000 + 64'(acc_idx * 4);
      out_ready   = (cyc >= 4);
      #1;
      if (cyc == 2) begin
        chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
        held_pc = out_pc;
        chk("bp_or_head", out_pc, 64'h2000);
      end
      if (cyc == 3) chk("bp_or_stable", out_pc, held_pc);
      if (out_valid && out_ready) begin
        chk($sformatf("bp_order_pc%0d", got), out_pc, 64'h2000 + 64'(got * 4));
        chk($sformatf("bp_order_imm%0d", got), imm, bp_imm[got]);
        got++;
      end
      if (in_valid && in_ready) acc_idx++;
      @(posedge clk);
    end
    in_valid = 1'b0;
    chk("bp_count", 64'(got), 64'd4);
    #1;
    chk("bp_no_dup", {63'd0, out_valid}, 64'd0);

    // Flush with both registers full and an input offered.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; instruction = 32'h00100013; pc = 64'h3000;
    @(negedge clk);
    instruction = 32'h00200013; pc = 64'h3004;
    @(negedge clk);
    chk("fl_full", {63'd0, in_ready}, 64'd0);
    instruction = 32'h00300013; pc = 64'h3008; flush = 1'b1;
    @(posedge clk); #1;
    chk("fl_out_valid", {63'd0, out_valid}, 64'd0);
    chk("fl_in_ready",  {63'd0, in_ready},  64'd1);
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b1;
    instruction = 32'h00400013; pc = 64'h300C;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("fl_next_valid", {63'd0, out_valid}, 64'd1);
    chk("fl_next_pc", out_pc, 64'h300C);
    chk("fl_next_imm", imm, 64'h4);
    @(posedge clk); #1;
    chk("fl_after_idle", {63'd0, out_valid}, 64'd0);

    // Reset during back-pressure clears everything.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; instruction = 32'hFE000CE3; pc = 64'h100;
    @(negedge clk);
    instruction = 32'h0010006F; pc = 64'h200;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("rst_bp_valid",    {63'd0, out_valid}, 64'd0);
    chk("rst_bp_in_ready", {63'd0, in_ready},  64'd1);
    chk("rst_bp_imm",      imm,                64'd0);
    chk("rst_bp_fmt",      {61'd0, imm_fmt},   64'd0);
    chk("rst_bp_target",   target,             64'd0);
    chk("rst_bp_pc",       out_pc,             64'd0);
    @(negedge clk);
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
